// File: rtl/alu_rs.sv
// alu_rs: age-ordered collapsing ALU reservation station, ALU_RS_WAKEUP_BYPASS_EN enables 0-cycle CDB wakeup
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 4
`endif
`ifndef ADD
`define ADD 4'd1
`endif
`ifndef SUB
`define SUB 4'd2
`endif
`ifndef AND
`define AND 4'd3
`endif
`ifndef OR
`define OR 4'd4
`endif
module alu_rs #(
  parameter int RS_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        disp_valid,
  output logic                        disp_ready,
  input  logic [3:0]                  disp_op,
  input  logic [`ROB_ENTRY_WIDTH-1:0] disp_dest,
  input  logic [31:0]                 disp_vj,
  input  logic [31:0]                 disp_vk,
  input  logic [`ROB_ENTRY_WIDTH-1:0] disp_qj,
  input  logic [`ROB_ENTRY_WIDTH-1:0] disp_qk,
  input  logic                        disp_rj,
  input  logic                        disp_rk,
  input  logic                        cdb_valid,
  input  logic [`ROB_ENTRY_WIDTH-1:0] cdb_tag,
  input  logic [31:0]                 cdb_data,
  input  logic                        flush,
  output logic [3:0]                  ALUOp,
  output logic [31:0]                 ALUSrcA,
  output logic [31:0]                 ALUSrcB,
  output logic [`ROB_ENTRY_WIDTH-1:0] Dest
);
  localparam int RW = `ROB_ENTRY_WIDTH;
  localparam int CW = $clog2(RS_DEPTH + 1);
`ifdef ALU_RS_WAKEUP_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  typedef struct packed {
    logic [3:0]    op;
    logic [RW-1:0] dest;
    logic [31:0]   vj;
    logic [31:0]   vk;
    logic [RW-1:0] qj;
    logic [RW-1:0] qk;
    logic          rj;
    logic          rk;
  } ent_t;
  ent_t q [RS_DEPTH];
  ent_t w [RS_DEPTH];
  ent_t nq [RS_DEPTH];
  ent_t de, ie;
  logic [CW-1:0] count, count_n;
  logic iss, acc;
  int sel, tail;
  function automatic ent_t wake(input ent_t e, input logic cv, input logic [RW-1:0] ct, input logic [31:0] cd);
    ent_t r;
    logic hj, hk;
    hj = !e.rj && cv && e.qj == ct;
    hk = !e.rk && cv && e.qk == ct;
    r = e;
    r.vj = hj ? cd : e.vj;
    r.vk = hk ? cd : e.vk;
    r.rj = e.rj || hj;
    r.rk = e.rk || hk;
    return r;
  endfunction
  assign disp_ready = count < CW'(RS_DEPTH);
  always_comb begin
    de = wake({disp_op, disp_dest, disp_vj, disp_vk, disp_qj, disp_qk, disp_rj, disp_rk}, cdb_valid, cdb_tag, cdb_data);
    iss = 1'b0;
    sel = 0;
    ie = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      w[i] = wake(q[i], cdb_valid, cdb_tag, cdb_data);
      if (i < int'(count) && (BYPASS ? w[i].rj && w[i].rk : q[i].rj && q[i].rk)) begin
        iss = 1'b1;
        sel = i;
        ie = w[i];
      end
    end
    acc = disp_valid && disp_ready;
    tail = int'(count) - int'(iss);
    for (int i = 0; i < RS_DEPTH; i++)
      nq[i] = acc && i == tail ? de : iss && i >= sel ? w[i < RS_DEPTH - 1 ? i + 1 : i] : w[i];
    count_n = count + CW'(acc) - CW'(iss);
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
      ALUOp <= '0;
      ALUSrcA <= '0;
      ALUSrcB <= '0;
      Dest <= '0;
    end else begin
      count <= count_n;
      q <= nq;
      ALUOp <= ie.op;
      ALUSrcA <= ie.vj;
      ALUSrcB <= ie.vk;
      Dest <= ie.dest;
    end
  end
endmodule
